// File: rtl/axi_wr_arbiter_pkg.sv
// Shared definitions for the two-requester AXI write arbiter.
package axi_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int         REQ_LOADER = 0;
    localparam int         REQ_CPU    = 1;
    localparam logic [1:0] BRESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter (loader, cpu) onto one memory port; ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: request in IDLE reaches m_* one cycle later; AW/W/B forwarded combinationally from the latched grant.
// Backpressure: one transaction outstanding; the non-granted requester sees no readies until the port frees.
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    input  logic                    s0_bready,
    output logic                    s0_bvalid,
    output logic [1:0]              s0_bresp,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic                    s1_bready,
    output logic                    s1_bvalid,
    output logic [1:0]              s1_bresp,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic                    m_bready,
    input  logic                    m_bvalid,
    input  logic [1:0]              m_bresp,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic [7:0]              err_cnt
);

    state_e     r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic       r_aw_done, r_w_done;
    logic [7:0] r_err_cnt;

    logic w_req0, w_req1, w_xfer, w_resp;
    logic w_g_awvalid, w_g_wvalid, w_g_bready;
    logic w_aw_rdy, w_w_rdy, w_aw_hs, w_w_hs, w_b_hs;

    assign w_req0 = s0_awvalid | s0_wvalid;
    assign w_req1 = s1_awvalid | s1_wvalid;
    assign w_xfer = (r_state == XFER);
    assign w_resp = (r_state == RESP);

    assign w_g_awvalid = (r_grant[REQ_LOADER] & s0_awvalid) | (r_grant[REQ_CPU] & s1_awvalid);
    assign w_g_wvalid  = (r_grant[REQ_LOADER] & s0_wvalid)  | (r_grant[REQ_CPU] & s1_wvalid);
    assign w_g_bready  = (r_grant[REQ_LOADER] & s0_bready)  | (r_grant[REQ_CPU] & s1_bready);

    assign m_awaddr  = r_grant[REQ_CPU] ? s1_awaddr : s0_awaddr;
    assign m_wdata   = r_grant[REQ_CPU] ? s1_wdata  : s0_wdata;
    assign m_wstrb   = r_grant[REQ_CPU] ? s1_wstrb  : s0_wstrb;
    assign m_awvalid = w_xfer & w_g_awvalid & ~r_aw_done;
    assign m_wvalid  = w_xfer & w_g_wvalid & ~r_w_done;
    assign m_bready  = w_resp & w_g_bready;

    assign w_aw_rdy = w_xfer & m_awready & ~r_aw_done;
    assign w_w_rdy  = w_xfer & m_wready & ~r_w_done;
    assign w_aw_hs  = m_awvalid & m_awready;
    assign w_w_hs   = m_wvalid & m_wready;
    assign w_b_hs   = m_bvalid & m_bready;

    assign s0_awready = r_grant[REQ_LOADER] & w_aw_rdy;
    assign s1_awready = r_grant[REQ_CPU] & w_aw_rdy;
    assign s0_wready  = r_grant[REQ_LOADER] & w_w_rdy;
    assign s1_wready  = r_grant[REQ_CPU] & w_w_rdy;
    assign s0_bvalid  = r_grant[REQ_LOADER] & w_resp & m_bvalid;
    assign s1_bvalid  = r_grant[REQ_CPU] & w_resp & m_bvalid;
    assign s0_bresp   = (r_grant[REQ_LOADER] & w_resp) ? m_bresp : 2'b00;
    assign s1_bresp   = (r_grant[REQ_CPU] & w_resp) ? m_bresp : 2'b00;

    assign grant   = r_grant;
    assign busy    = (r_state != IDLE);
    assign err_cnt = r_err_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer names the requester that wins the next tie: the one not served last.
    logic r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_b_hs) begin
            r_rr_ptr <= r_grant[REQ_LOADER];
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = XFER;
`ifdef ARB_ROUND_ROBIN_EN
                    if (w_req0 & w_req1) begin
                        w_grant_nxt = r_rr_ptr ? 2'b10 : 2'b01;
                    end else begin
                        w_grant_nxt = w_req0 ? 2'b01 : 2'b10;
                    end
`else
                    w_grant_nxt = w_req0 ? 2'b01 : 2'b10;
`endif
                end
            end
            XFER: begin
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_b_hs && (m_bresp != BRESP_OKAY) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule
